// File: rtl/memaccess_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : memaccess_pkg
//  Brief    : Shared word size, state encoding and alignment helper for the
//             LEGv8 memory-stage access controller.
//  Revision : 1.0  initial release
// ============================================================================
package memaccess_pkg;

    localparam int WORDSIZE            = 64;
    localparam int MEMACCESS_STATESIZE = 2;
    localparam int ALIGNBITS           = $clog2(WORDSIZE / 8);

    typedef enum logic [MEMACCESS_STATESIZE-1:0] {
        MEMACCESS_IDLE = 2'd0,
        MEMACCESS_WAIT = 2'd1,
        MEMACCESS_DONE = 2'd2
    } memaccess_state_e;

    function automatic logic is_misaligned(input logic [WORDSIZE-1:0] a);
        return a[ALIGNBITS-1:0] != '0;
    endfunction

endpackage : memaccess_pkg
`default_nettype wire

// File: rtl/memaccess_memwatchdog.sv
`default_nettype none
// ============================================================================
//  Module   : memwatchdog
//  Brief    : Wait-cycle counter; expired_o flags the TIMEOUT-th counted cycle.
//  Revision : 1.0  initial release
// ============================================================================
module memwatchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNTW = $clog2(TIMEOUT + 1);

    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires during the cycle that would make the count reach TIMEOUT.
    assign expired_o = enable_i && (count_q == CNTW'(TIMEOUT - 1));

endmodule : memwatchdog
`default_nettype wire

// File: rtl/memaccess.sv
`default_nettype none
// ============================================================================
//  Module   : memaccess
//  Brief    : MEM-stage request/ack controller; stalls the pipe and bubbles
//             MEM/WB while a data-memory access is outstanding.
//             Optional wait timeout: define MEMACCESS_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module memaccess
    import memaccess_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                exvalid,
    input  logic                memread,
    input  logic                memwrite,
    input  logic [WORDSIZE-1:0] addr,
    input  logic [WORDSIZE-1:0] wdata,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [WORDSIZE-1:0] dmem_addr,
    output logic [WORDSIZE-1:0] dmem_wdata,
    input  logic                dmem_ack,
    input  logic                dmem_err,
    input  logic [WORDSIZE-1:0] dmem_rdata,
    output logic [WORDSIZE-1:0] readmem,
    output logic                stall,
    output logic                bubble,
    output logic                fault
);

    memaccess_state_e    state_q, state_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [WORDSIZE-1:0] addr_q, addr_d;
    logic [WORDSIZE-1:0] wdata_q, wdata_d;
    logic [WORDSIZE-1:0] readmem_q, readmem_d;
    logic                fault_q, fault_d;

    logic w_memop;
    logic w_illegal;
    logic w_timeout;

    assign w_memop   = exvalid & (memread | memwrite);
    assign w_illegal = (memread & memwrite) | is_misaligned(addr);

`ifdef MEMACCESS_TIMEOUT_EN
    memwatchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_memwatchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (state_q != MEMACCESS_WAIT),
        .enable_i  ((state_q == MEMACCESS_WAIT) & ~dmem_ack),
        .expired_o (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        readmem_d = readmem_q;
        fault_d   = fault_q;
        stall     = 1'b0;
        bubble    = 1'b0;
        fault     = 1'b0;

        case (state_q)
            MEMACCESS_IDLE: begin
                if (w_memop) begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    if (w_illegal) begin
                        fault_d = 1'b1;
                        state_d = MEMACCESS_DONE;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = memwrite;
                        addr_d  = addr;
                        wdata_d = wdata;
                        fault_d = 1'b0;
                        state_d = MEMACCESS_WAIT;
                    end
                end
            end
            MEMACCESS_WAIT: begin
                stall  = 1'b1;
                bubble = 1'b1;
                // An ack arriving on the timeout cycle takes precedence.
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    state_d = MEMACCESS_DONE;
                    if (dmem_err) begin
                        fault_d   = 1'b1;
                        readmem_d = '0;
                    end else if (!we_q) begin
                        readmem_d = dmem_rdata;
                    end
                end else if (w_timeout) begin
                    req_d     = 1'b0;
                    readmem_d = '0;
                    fault_d   = 1'b1;
                    state_d   = MEMACCESS_DONE;
                end
            end
            MEMACCESS_DONE: begin
                bubble  = fault_q;
                fault   = fault_q;
                fault_d = 1'b0;
                state_d = MEMACCESS_IDLE;
            end
            default: begin
                state_d = MEMACCESS_IDLE;
            end
        endcase

        if (!rst_n) begin
            stall  = 1'b0;
            bubble = 1'b1;
            fault  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= MEMACCESS_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            readmem_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            readmem_q <= readmem_d;
            fault_q   <= fault_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign readmem    = readmem_q;

endmodule : memaccess
`default_nettype wire

// File: tb/tb_memaccess.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memaccess
//  Brief    : Self-checking bench for memaccess: directed cases plus random
//             load/store transactions against a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_memaccess;
    import memaccess_pkg::*;

    localparam int W  = WORDSIZE;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         exvalid, memread, memwrite;
    logic [W-1:0] addr, wdata;
    logic         dmem_req, dmem_we;
    logic [W-1:0] dmem_addr, dmem_wdata;
    logic         dmem_ack, dmem_err;
    logic [W-1:0] dmem_rdata;
    logic [W-1:0] readmem;
    logic         stall, bubble, fault;

    always #5 clk = ~clk;

    memaccess #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .exvalid    (exvalid),
        .memread    (memread),
        .memwrite   (memwrite),
        .addr       (addr),
        .wdata      (wdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_err   (dmem_err),
        .dmem_rdata (dmem_rdata),
        .readmem    (readmem),
        .stall      (stall),
        .bubble     (bubble),
        .fault      (fault)
    );

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] exp_readmem;

    task automatic check_value(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        return {$urandom(), $urandom()};
    endfunction

    // One cycle with no memory instruction; stray acks must be ignored.
    task automatic idle_cycle(input string tag);
        @(negedge clk);
        exvalid    = $urandom_range(0, 1);
        memread    = ~exvalid & $urandom_range(0, 1);
        memwrite   = 1'b0;
        addr       = rand_word();
        dmem_ack   = $urandom_range(0, 1);
        dmem_err   = $urandom_range(0, 1);
        dmem_rdata = rand_word();
        #1;
        check_value({tag, "_stall"},  W'(stall),  '0);
        check_value({tag, "_bubble"}, W'(bubble), '0);
        check_value({tag, "_fault"},  W'(fault),  '0);
        check_value({tag, "_rmem"},   readmem,    exp_readmem);
    endtask

    // lat: WAIT cycle index (1 = first) carrying the ack; 0 = never ack.
    // Returns at the DONE cycle so a following access runs back-to-back.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [W-1:0] a, input logic [W-1:0] wd,
                              input int lat, input logic err, input logic [W-1:0] rdata);
        bit illegal, timed_out, exp_fault, done, saw_req, stall_bad, pay_bad;
        int eff_wait, exp_stall, stalls, waitc;
        illegal   = (rd && wr) || (a[2:0] != 3'b000);
        timed_out = 0;
        eff_wait  = lat;
`ifdef MEMACCESS_TIMEOUT_EN
        if (lat == 0 || lat > TO) begin
            timed_out = 1;
            eff_wait  = TO;
        end
`endif
        exp_fault = illegal || timed_out || err;
        exp_stall = illegal ? 1 : eff_wait + 1;
        if (!illegal) begin
            if (timed_out || err) exp_readmem = '0;
            else if (rd)          exp_readmem = rdata;
        end
        stalls = 0; waitc = 0; done = 0; saw_req = 0; stall_bad = 0; pay_bad = 0;

        @(negedge clk);
        exvalid = 1'b1; memread = rd; memwrite = wr; addr = a; wdata = wd;
        dmem_ack = 1'b0; dmem_err = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            #1;
            if (stall) begin
                stalls++;
                if (bubble !== 1'b1 || fault !== 1'b0) stall_bad = 1;
                if (dmem_req) begin
                    saw_req = 1;
                    waitc++;
                    if (dmem_we !== wr || dmem_addr !== a || dmem_wdata !== wd) pay_bad = 1;
                end
                if (dmem_req && waitc == lat) begin
                    dmem_ack = 1'b1; dmem_err = err; dmem_rdata = rdata;
                end else begin
                    dmem_ack = 1'b0; dmem_err = $urandom_range(0, 1); dmem_rdata = rand_word();
                end
                @(negedge clk);
                dmem_ack = 1'b0;
            end else begin
                done = 1;
            end
        end
        check_value({tag, "_finished"},  W'(done),      W'(1));
        check_value({tag, "_stalls"},    W'(stalls),    W'(exp_stall));
        check_value({tag, "_stallflags"},W'(stall_bad), '0);
        check_value({tag, "_reqissued"}, W'(saw_req),   W'(!illegal));
        check_value({tag, "_payload"},   W'(pay_bad),   '0);
        check_value({tag, "_done_req"},  W'(dmem_req),  '0);
        check_value({tag, "_done_bub"},  W'(bubble),    W'(exp_fault));
        check_value({tag, "_done_flt"},  W'(fault),     W'(exp_fault));
        check_value({tag, "_rmem"},      readmem,       exp_readmem);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; exvalid = 1'b0; memread = 1'b0; memwrite = 1'b0;
        addr = '0; wdata = '0; dmem_ack = 1'b0; dmem_err = 1'b0; dmem_rdata = '0;
        exp_readmem = '0;

        // Reset: outputs forced while low, registers cleared after
        repeat (2) @(negedge clk);
        exvalid = 1'b1; memread = 1'b1;
        #1;
        check_value("rst_stall",  W'(stall),  '0);
        check_value("rst_bubble", W'(bubble), W'(1));
        check_value("rst_fault",  W'(fault),  '0);
        @(negedge clk);
        rst_n = 1'b1; exvalid = 1'b0; memread = 1'b0;
        #1;
        check_value("rst_req",   W'(dmem_req), '0);
        check_value("rst_we",    W'(dmem_we),  '0);
        check_value("rst_addr",  dmem_addr,    '0);
        check_value("rst_wdata", dmem_wdata,   '0);
        check_value("rst_rmem",  readmem,      '0);
        idle_cycle("idle0");

        // Directed cases
        run_access("ld_wait3", 1, 0, W'(64'h10), rand_word(), 3, 0, W'(64'hDEADBEEF));
        idle_cycle("idle1");
        run_access("st_zero", 0, 1, W'(64'h20), W'(64'h55), 1, 0, rand_word());
        idle_cycle("idle2");
        run_access("ld_misal", 1, 0, W'(64'h13), rand_word(), 2, 0, rand_word());
        idle_cycle("idle3");
        run_access("ld_rw", 1, 1, W'(64'h18), rand_word(), 2, 0, rand_word());
        run_access("ld_err", 1, 0, W'(64'h28), rand_word(), 2, 1, rand_word());
        idle_cycle("after_err");
        run_access("ld_b2b_a", 1, 0, W'(64'h30), rand_word(), 1, 0, W'(64'h1234));
        run_access("ld_b2b_b", 1, 0, W'(64'h38), rand_word(), 2, 0, W'(64'h5678));

        // Reset in the second WAIT cycle, ack arriving a cycle later
        @(negedge clk);
        exvalid = 1'b1; memread = 1'b1; memwrite = 1'b0; addr = W'(64'h40);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_value("rstw_stall",  W'(stall),  '0);
        check_value("rstw_bubble", W'(bubble), W'(1));
        @(negedge clk);
        rst_n = 1'b1; exvalid = 1'b0; memread = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = W'(64'hBAD0BAD0);
        exp_readmem = '0;
        #1;
        check_value("rstw_req",   W'(dmem_req), '0);
        check_value("rstw_stall2",W'(stall),    '0);
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        check_value("rstw_req2", W'(dmem_req), '0);
        check_value("rstw_rmem", readmem,      '0);
        check_value("rstw_idle", W'(stall),    '0);

`ifdef MEMACCESS_TIMEOUT_EN
        run_access("ld_tmo", 1, 0, W'(64'h48), rand_word(), 0, 0, rand_word());
        idle_cycle("after_tmo");
        run_access("ld_tmo_ack", 1, 0, W'(64'h50), rand_word(), TO, 0, W'(64'hCAFE));
`else
        // No timeout: the access is still pending 100 cycles later
        @(negedge clk);
        exvalid = 1'b1; memread = 1'b1; addr = W'(64'h48); dmem_ack = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        check_value("notmo_stall", W'(stall),    W'(1));
        check_value("notmo_req",   W'(dmem_req), W'(1));
        check_value("notmo_fault", W'(fault),    '0);
        rst_n = 1'b0; exvalid = 1'b0; memread = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_readmem = '0;
`endif
        idle_cycle("idle4");

        // Random traffic; occasional idle gaps between accesses
        for (int t = 0; t < 60; t++) begin
            logic         rd, wr, err;
            logic [W-1:0] a;
            int           kind;
            kind = $urandom_range(0, 9);
            rd   = (kind != 0);
            wr   = (kind == 0) || (kind == 1 && $urandom_range(0, 1) == 1);
            if (kind >= 5) wr = $urandom_range(0, 1);
            if (wr && kind >= 5) rd = 1'b0;
            a    = rand_word();
            if ($urandom_range(0, 5) != 0) a[2:0] = 3'b000;
            err  = ($urandom_range(0, 6) == 0);
            run_access($sformatf("rnd%0d", t), rd, wr, a, rand_word(),
                       $urandom_range(1, 4), err, rand_word());
            if ($urandom_range(0, 2) == 0) idle_cycle($sformatf("rndidle%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_memaccess
`default_nettype wire
